// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow clock (clk_in) in sys_clk cycles,
// and flags clk_stuck when no rising edge has been seen for TIMEOUT cycles.
module clk_period_meter #(
  parameter int          CNT_W   = 16,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             clk_stuck
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO      = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic             rise;
  logic             timeout_hit;

  // s1/s2 form the synchroniser; s3 only delays s2 for edge detection.
  assign rise        = s2 & ~s3;
  assign timeout_hit = (per_cnt == TO_M1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= IDLE;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      clk_stuck  <= 1'b0;
    end else begin
      s1         <= clk_in;
      s2         <= s1;
      s3         <= s2;
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            // First edge only establishes the reference point.
            state     <= MEASURE;
            per_cnt   <= ONE;
            hi_cnt    <= ONE;
            clk_stuck <= 1'b0;
          end else begin
            if (per_cnt < TO) per_cnt <= per_cnt + ONE;
            if (timeout_hit) clk_stuck <= 1'b1;
          end
        end
        MEASURE: begin
          if (rise) begin
            period     <= per_cnt;
            high_time  <= hi_cnt;
            meas_valid <= 1'b1;
            per_cnt    <= ONE;
            hi_cnt     <= ONE;
          end else if (timeout_hit) begin
            // Abandon the measurement; the outputs keep the last good result.
            state     <= IDLE;
            clk_stuck <= 1'b1;
            per_cnt   <= TO;
          end else begin
            if (per_cnt != CNT_MAX) per_cnt <= per_cnt + ONE;
            if (s2 && (hi_cnt != CNT_MAX)) hi_cnt <= hi_cnt + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: two instances (16-bit/TIMEOUT=20 and
// 4-bit/TIMEOUT=15) driven with hand-built clk_in patterns.
module tb_clk_period_meter;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        clk_a, clk_b;
  logic [15:0] period_a, high_a;
  logic        mv_a, stuck_a;
  logic [3:0]  period_b, high_b;
  logic        mv_b, stuck_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 sys_clk = ~sys_clk;

  clk_period_meter #(.CNT_W(16), .TIMEOUT(20)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(rst_n), .clk_in(clk_a),
    .period(period_a), .high_time(high_a), .meas_valid(mv_a), .clk_stuck(stuck_a)
  );

  clk_period_meter #(.CNT_W(4), .TIMEOUT(15)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(rst_n), .clk_in(clk_b),
    .period(period_b), .high_time(high_b), .meas_valid(mv_b), .clk_stuck(stuck_b)
  );

  // Pattern value at cycle idx for a clock that is hi cycles high, lo cycles low.
  function automatic logic pat(input int idx, input int hi, input int lo);
    return (idx % (hi + lo)) < hi;
  endfunction

  // One sys_clk cycle: drive just after the rising edge, sample at the falling edge.
  task automatic step_a(input logic v);
    @(posedge sys_clk);
    #1 clk_a = v;
    @(negedge sys_clk);
  endtask

  task automatic step_b(input logic v);
    @(posedge sys_clk);
    #1 clk_b = v;
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    clk_a = 1'b0;
    clk_b = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clk_a = 1'b0;
    clk_b = 1'b0;
    @(negedge sys_clk);
    checks++;
    if ({period_a, high_a, mv_a, stuck_a} !== 34'd0) begin
      errors++;
      $display("FAIL reset_a: got period=%0d high=%0d mv=%b stuck=%b, want all 0",
               period_a, high_a, mv_a, stuck_a);
    end
    checks++;
    if ({period_b, high_b, mv_b, stuck_b} !== 10'd0) begin
      errors++;
      $display("FAIL reset_b: got period=%0d high=%0d mv=%b stuck=%b, want all 0",
               period_b, high_b, mv_b, stuck_b);
    end
  endtask

  task automatic test_div5();
    int n_pulse = 0;
    int last = -1;
    do_reset();
    for (int k = 0; k < 50; k++) begin
      step_a(pat(k, 2, 3));
      if (mv_a) begin
        n_pulse++;
        checks++;
        if (period_a !== 16'd5 || high_a !== 16'd2) begin
          errors++;
          $display("FAIL div5_value k=%0d: got %0d/%0d, want 5/2", k, period_a, high_a);
        end
        checks++;
        if ((last < 0 && k !== 8) || (last >= 0 && k - last !== 5)) begin
          errors++;
          $display("FAIL div5_timing k=%0d: previous pulse at %0d, want first at 8 then every 5", k, last);
        end
        last = k;
      end
    end
    checks++;
    if (n_pulse !== 9) begin
      errors++;
      $display("FAIL div5_count: got %0d pulses, want 9", n_pulse);
    end
  endtask

  task automatic test_duty_change();
    logic stim[$];
    logic [31:0] exp;
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 48; k++) stim.push_back(pat(k, 4, 4));
    for (int k = 0; k < 6; k++)  stim.push_back(k < 4);
    for (int k = 0; k < 24; k++) stim.push_back(pat(k, 1, 2));
    for (int k = 0; k < 4; k++)  stim.push_back(1'b0);
    for (int k = 0; k < 6; k++)  exp_q.push_back({16'd8, 16'd4});
    exp_q.push_back({16'd6, 16'd4});
    for (int k = 0; k < 7; k++)  exp_q.push_back({16'd3, 16'd1});
    foreach (stim[k]) begin
      step_a(stim[k]);
      if (mv_a) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL duty_extra k=%0d: unexpected report %0d/%0d", k, period_a, high_a);
        end else begin
          exp = exp_q.pop_front();
          if ({period_a, high_a} !== exp) begin
            errors++;
            $display("FAIL duty_value k=%0d: got %0d/%0d, want %0d/%0d",
                     k, period_a, high_a, exp[31:16], exp[15:0]);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL duty_missing: %0d reports never arrived, want 0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    logic v;
    logic exp_mv, exp_stuck;
    do_reset();
    for (int k = 0; k < 54; k++) begin
      if (k < 15)      v = pat(k, 2, 3);
      else if (k < 40) v = 1'b0;
      else if (k < 50) v = pat(k - 40, 2, 3);
      else             v = 1'b0;
      step_a(v);
      exp_mv    = (k == 8) || (k == 13) || (k == 48);
      exp_stuck = (k >= 32) && (k <= 42);
      checks++;
      if (mv_a !== exp_mv || stuck_a !== exp_stuck) begin
        errors++;
        $display("FAIL timeout_flags k=%0d: got mv=%b stuck=%b, want mv=%b stuck=%b",
                 k, mv_a, stuck_a, exp_mv, exp_stuck);
      end
      if (k >= 8) begin
        checks++;
        if (period_a !== 16'd5 || high_a !== 16'd2) begin
          errors++;
          $display("FAIL timeout_hold k=%0d: got %0d/%0d, want 5/2", k, period_a, high_a);
        end
      end
    end
  endtask

  task automatic test_stuck_high();
    rst_n = 1'b0;
    clk_a = 1'b1;
    clk_b = 1'b0;
    repeat (2) @(posedge sys_clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step_a(1'b1);
      checks++;
      if (mv_a !== 1'b0) begin
        errors++;
        $display("FAIL stuck_high_mv k=%0d: got mv=%b, want 0", k, mv_a);
      end
    end
    checks++;
    if (stuck_a !== 1'b1 || period_a !== 16'd0 || high_a !== 16'd0) begin
      errors++;
      $display("FAIL stuck_high_end: got stuck=%b period=%0d high=%0d, want 1/0/0",
               stuck_a, period_a, high_a);
    end
  endtask

  task automatic test_async_reset();
    logic exp_mv;
    do_reset();
    for (int k = 0; k < 14; k++) step_a(pat(k, 2, 3));
    checks++;
    if (mv_a !== 1'b1 || period_a !== 16'd5) begin
      errors++;
      $display("FAIL areset_pre: got mv=%b period=%0d, want 1/5", mv_a, period_a);
    end
    @(posedge sys_clk);
    clk_a = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({period_a, high_a, mv_a, stuck_a} !== 34'd0) begin
      errors++;
      $display("FAIL areset_now: got period=%0d high=%0d mv=%b stuck=%b, want all 0",
               period_a, high_a, mv_a, stuck_a);
    end
    @(posedge sys_clk);
    #7 rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step_a(pat(j, 2, 3));
      exp_mv = (j == 8) || (j == 13) || (j == 18);
      checks++;
      if (mv_a !== exp_mv) begin
        errors++;
        $display("FAIL areset_mv j=%0d: got %b, want %b", j, mv_a, exp_mv);
      end
      checks++;
      if (j < 8 && period_a !== 16'd0) begin
        errors++;
        $display("FAIL areset_early j=%0d: got period=%0d, want 0", j, period_a);
      end else if (j >= 8 && (period_a !== 16'd5 || high_a !== 16'd2)) begin
        errors++;
        $display("FAIL areset_value j=%0d: got %0d/%0d, want 5/2", j, period_a, high_a);
      end
    end
  endtask

  task automatic test_cnt_w4();
    logic v;
    logic exp_mv, exp_stuck;
    do_reset();
    for (int k = 0; k < 108; k++) begin
      if (k < 56)       v = pat(k, 7, 7);
      else if (k < 104) v = pat(k - 56, 8, 8);
      else              v = 1'b0;
      step_b(v);
      exp_mv    = (k == 17) || (k == 31) || (k == 45) || (k == 59);
      exp_stuck = (k == 73) || (k == 74) || (k == 89) || (k == 90) || (k >= 105);
      checks++;
      if (mv_b !== exp_mv || stuck_b !== exp_stuck) begin
        errors++;
        $display("FAIL w4_flags k=%0d: got mv=%b stuck=%b, want mv=%b stuck=%b",
                 k, mv_b, stuck_b, exp_mv, exp_stuck);
      end
      if (k >= 17) begin
        checks++;
        if (period_b !== 4'd14 || high_b !== 4'd7) begin
          errors++;
          $display("FAIL w4_value k=%0d: got %0d/%0d, want 14/7", k, period_b, high_b);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_div5();
    test_duty_change();
    test_timeout();
    test_stuck_high();
    test_async_reset();
    test_cnt_w4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
